rs_circ_encoder: RTL and testbench
==================================

// Module: rs_circ_encoder
// PURPOSE
//  Systematic Reed-Solomon encoder over GF(256) (poly 0x11D, alpha=0x02), 4 parity symbols.
//  Generator g(x)=(x+a^0)(x+a^1)(x+a^2)(x+a^3) = x^4+0x0F x^3+0x36 x^2+0x78 x+0x40.
//  Counterpart to the RS decode path: it produces the C1/C2 codewords the decoder consumes.
//  It also acts as the stimulus source for decoder self-test.
//  Byte-serial LFSR with valid/ready streaming on both sides; constant mults via gf256_mult.
// PARAMETERS
//  N  32  codeword length in symbols (C1=32, C2=28); parity count fixed at 4
//  K  28  message length in symbols; K = N-4 required, K >= 1
// PORTS
//  i_clk        in   1  clock, all logic on rising edge
//  i_rst        in   1  synchronous reset, active-high
//  i_data       in   8  message symbol, first symbol = highest-degree coefficient
//  i_valid      in   1  i_data valid
//  o_ready      out  1  encoder accepts i_data this cycle
//  o_data       out  8  codeword symbol (K message symbols, then 4 parity)
//  o_valid      out  1  o_data valid
//  i_ready      in   1  downstream accepts o_data
//  o_parity     out  1  current o_data is a parity symbol
//  o_last       out  1  current o_data is symbol N-1 of the codeword
// BEHAVIOUR
//  Reset: o_valid=0, o_data=0, o_parity=0, o_last=0, LFSR r[3:0]=0, count=0, state=MSG.
//  Output register: o_data/o_valid/o_parity/o_last are flops; a slot is free when
//   !o_valid || i_ready. Output advances only on a free slot; stalls hold all outputs stable.
//  State MSG (count 0..K-1):
//   o_ready = free slot (combinational from o_valid, i_ready; no path from i_valid).
//   On accept (i_valid && o_ready): fb = i_data ^ r3;
//    r3<=r2^fb*0x0F; r2<=r1^fb*0x36; r1<=r0^fb*0x78; r0<=fb*0x40;
//    o_data<=i_data, o_valid<=1, o_parity<=0, o_last<=0, count++.
//   No accept + free slot: o_valid<=0. Latency in->out: 1 cycle.
//   Accept of message symbol K-1 -> state PAR, count=0.
//  State PAR (count 0..3): o_ready=0.
//   On free slot: o_data<=r3, o_valid<=1, o_parity<=1, o_last<=(count==3);
//    shift r3<=r2, r2<=r1, r1<=r0, r0<=0; count++.
//   Parity order: r3 first (x^3 coeff) through r0 last.
//   After emitting parity 3 -> state MSG, count=0, LFSR all zero.
//   First parity enters o_data on the first free slot after the last message symbol leaves.
//  Back-to-back: next codeword's first symbol is accepted the cycle after o_last loads.
//   Throughput N symbols per N+0 output beats, with no bubble when i_ready=1.
//  i_valid gaps mid-message are legal; the LFSR holds.
//  Reset mid-codeword: discard partial codeword, return to reset values next edge.
//  GF mult: gf256_mult with a constant B operand; XOR is addition; all widths 8 bits.
// TESTING
//  1. K zero symbols, i_ready=1 -> N zero outputs; o_parity high on last 4; o_last on the 32nd.
//  2. d[0..K-2]=0, d[K-1]=0x01 -> parity 0x0F,0x36,0x78,0x40, in that order.
//  3. Random messages (N=32 and N=28) vs C model; each codeword evaluates to 0 at a^0..a^3.
//  4. i_ready toggling randomly, i_valid gaps -> identical stream to case 3; stalled outputs
//     stay stable; no symbol lost or duplicated.
//  5. Three codewords back-to-back, i_ready=1 -> 3*N consecutive valid beats, o_last x3.
//  6. i_rst pulsed at message symbol 10, then vector of case 2 -> exact parity of case 2.

Source files
------------

// File: rtl/rs_circ_encoder.sv
// ---------------------------------------------------------------------------
// rs_circ_encoder
//   Systematic Reed-Solomon encoder over GF(256) (field poly 0x11D, alpha=0x02)
//   with 4 parity symbols. Generator polynomial:
//     g(x) = (x+a^0)(x+a^1)(x+a^2)(x+a^3) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40
//   Byte-serial LFSR. Message symbols pass straight through (1 cycle latency).
//   After K message symbols the 4 LFSR cells are shifted out as parity, r3 first.
//
//   Handshake (both sides): a symbol moves on a rising edge where valid && ready
//   are both high. Valid must not depend on ready. The output register slot is
//   "free" when it is empty or the downstream takes it this cycle
//   (!o_valid || i_ready); outputs only change on a free slot, so a stalled
//   symbol holds o_data/o_parity/o_last stable.
//
// Ports
//   i_clk      in   1  clock, rising edge
//   i_rst      in   1  synchronous reset, active-high
//   i_data     in   8  message symbol, highest-degree coefficient first
//   i_valid    in   1  i_data valid
//   o_ready    out  1  encoder accepts i_data this cycle
//   o_data     out  8  codeword symbol (K message, then 4 parity)
//   o_valid    out  1  o_data valid
//   i_ready    in   1  downstream accepts o_data
//   o_parity   out  1  current o_data is a parity symbol
//   o_last     out  1  current o_data is symbol N-1 of the codeword
//   dbg_state  out  1  FSM state: 0 = MSG, 1 = PAR
// ---------------------------------------------------------------------------
module rs_circ_encoder #(
    parameter int N = 32,
    parameter int K = 28
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_parity,
    output logic       o_last,
    output logic       dbg_state
);

    generate
        if (K != N - 4 || K < 1) begin : g_bad_params
            $error("rs_circ_encoder: K must equal N-4 and be at least 1");
        end
    endgenerate

    localparam int CW = (N > 4) ? $clog2(N) : 3;
    localparam logic [CW-1:0] LAST_MSG = CW'(K - 1);
    localparam logic [CW-1:0] LAST_PAR = CW'(3);

    // GF(256) multiply, poly 0x11D. With a constant b this collapses to an
    // XOR network.
    function automatic logic [7:0] gf256_mult(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return acc;
    endfunction

    typedef enum logic {ST_MSG = 1'b0, ST_PAR = 1'b1} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [7:0]    r0, r1, r2, r3;

    logic       free_slot;
    logic       accept;
    logic [7:0] fb;
    logic [7:0] fb_g3, fb_g2, fb_g1, fb_g0;

    assign free_slot = !o_valid || i_ready;
    // No path from i_valid: ready depends only on state and the output slot.
    assign o_ready   = (state == ST_MSG) && free_slot;
    assign accept    = i_valid && o_ready;
    assign dbg_state = (state == ST_PAR);

    assign fb    = i_data ^ r3;
    assign fb_g3 = gf256_mult(fb, 8'h0F);
    assign fb_g2 = gf256_mult(fb, 8'h36);
    assign fb_g1 = gf256_mult(fb, 8'h78);
    assign fb_g0 = gf256_mult(fb, 8'h40);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_MSG;
            count    <= '0;
            r0       <= 8'h00;
            r1       <= 8'h00;
            r2       <= 8'h00;
            r3       <= 8'h00;
            o_data   <= 8'h00;
            o_valid  <= 1'b0;
            o_parity <= 1'b0;
            o_last   <= 1'b0;
        end else begin
            case (state)
                ST_MSG: begin
                    if (accept) begin
                        r3       <= r2 ^ fb_g3;
                        r2       <= r1 ^ fb_g2;
                        r1       <= r0 ^ fb_g1;
                        r0       <= fb_g0;
                        o_data   <= i_data;
                        o_valid  <= 1'b1;
                        o_parity <= 1'b0;
                        o_last   <= 1'b0;
                        if (count == LAST_MSG) begin
                            state <= ST_PAR;
                            count <= '0;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end else if (free_slot) begin
                        o_valid <= 1'b0;
                    end
                end
                ST_PAR: begin
                    if (free_slot) begin
                        o_data   <= r3;
                        o_valid  <= 1'b1;
                        o_parity <= 1'b1;
                        o_last   <= (count == LAST_PAR);
                        // Shifting zeros in leaves the LFSR clear after the
                        // fourth parity, ready for the next codeword.
                        r3       <= r2;
                        r2       <= r1;
                        r1       <= r0;
                        r0       <= 8'h00;
                        if (count == LAST_PAR) begin
                            state <= ST_MSG;
                            count <= '0;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_MSG;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_circ_encoder.sv
// ---------------------------------------------------------------------------
// tb_rs_circ_encoder
//   Bench for rs_circ_encoder (N=32, K=28). Expected codewords come from a
//   polynomial long-division model; every completed output codeword is also
//   evaluated at a^0..a^3, where a valid RS codeword must be zero.
// ---------------------------------------------------------------------------
module tb_rs_circ_encoder;

  localparam int N = 32;
  localparam int K = 28;

  // ---------------- clock / reset ----------------
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b1;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_parity;
  logic       o_last;
  logic       dbg_state;

  always #5 i_clk = ~i_clk;

  rs_circ_encoder #(.N(N), .K(K)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_parity (o_parity),
    .o_last   (o_last),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];          // {parity, last, data}
  logic [7:0] msg_buf[K];
  logic [7:0] par_buf[4];
  bit checking = 1'b0;
  bit rand_ready = 1'b0;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  // Remainder of m(x)*x^4 divided by g(x) via long division.
  task automatic model_parity();
    logic [7:0] a[N];
    logic [7:0] g[5];
    logic [7:0] c;
    g[0] = 8'h01; g[1] = 8'h0F; g[2] = 8'h36; g[3] = 8'h78; g[4] = 8'h40;
    for (int i = 0; i < N; i++) a[i] = (i < K) ? msg_buf[i] : 8'h00;
    for (int i = 0; i < K; i++) begin
      c = a[i];
      for (int j = 0; j < 5; j++) a[i + j] = a[i + j] ^ gmul(c, g[j]);
    end
    for (int j = 0; j < 4; j++) par_buf[j] = a[K + j];
  endtask

  // ---------------- ready driver ----------------
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] cw_buf[N];
  int         cw_idx = 0;
  bit         held = 1'b0;
  logic [9:0] held_v = '0;

  always @(negedge i_clk) begin
    logic [9:0] got;
    logic [9:0] exp;
    logic [7:0] s;
    logic [7:0] x;
    got = {o_parity, o_last, o_data};
    if (i_rst || !checking) begin
      cw_idx = 0;
      held   = 1'b0;
    end else begin
      if (held) begin
        n_cmp++;
        if (!o_valid || got !== held_v) begin
          n_bad++;
          $display("FAIL stall_stable: got valid=%0b sym=%h required valid=1 sym=%h", o_valid, got, held_v);
        end
      end
      held   = o_valid && !i_ready;
      held_v = got;
      if (o_valid && i_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out: got %h required no output", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_bad++;
            $display("FAIL out_symbol: got {par,last,data}=%h required %h", got, exp);
          end
        end
        if (cw_idx < N) cw_buf[cw_idx] = o_data;
        cw_idx++;
        if (o_last) begin
          n_cmp++;
          if (cw_idx != N) begin
            n_bad++;
            $display("FAIL cw_length: got %0d required %0d", cw_idx, N);
          end else begin
            x = 8'h01;
            for (int r = 0; r < 4; r++) begin
              s = 8'h00;
              for (int i = 0; i < N; i++) s = gmul(s, x) ^ cw_buf[i];
              n_cmp++;
              if (s !== 8'h00) begin
                n_bad++;
                $display("FAIL syndrome_%0d: got %h required 00", r, s);
              end
              x = gmul(x, 8'h02);
            end
          end
          cw_idx = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Sends nsym symbols of msg_buf. For a full codeword the expected stream is
  // queued up front; const_par uses the impulse-response parity directly.
  task automatic send_cw(input int nsym, input bit gaps, input bit const_par);
    bit acc;
    if (nsym == K) begin
      if (const_par) begin
        par_buf[0] = 8'h0F; par_buf[1] = 8'h36; par_buf[2] = 8'h78; par_buf[3] = 8'h40;
      end else begin
        model_parity();
      end
      for (int i = 0; i < K; i++) exp_q.push_back({2'b00, msg_buf[i]});
      for (int j = 0; j < 4; j++) exp_q.push_back({1'b1, (j == 3), par_buf[j]});
    end else begin
      for (int i = 0; i < nsym; i++) exp_q.push_back({2'b00, msg_buf[i]});
    end
    for (int i = 0; i < nsym; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge i_clk);
        #1;
      end
      i_valid = 1'b1;
      i_data  = msg_buf[i];
      acc = 1'b0;
      for (int t = 0; t < 1000 && !acc; t++) begin
        @(negedge i_clk);
        acc = o_ready;
        @(posedge i_clk);
        #1;
      end
      if (!acc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got o_ready=0 required accept of symbol %0d", i);
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge i_clk);
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending symbols required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < K; i++) msg_buf[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge i_clk);
    n_cmp++;
    if ({o_valid, o_parity, o_last, o_data} !== 11'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%0b par=%0b last=%0b data=%h required all 0",
               o_valid, o_parity, o_last, o_data);
    end
    n_cmp++;
    if (o_ready !== 1'b1 || dbg_state !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got ready=%0b state=%0b required ready=1 state=0", o_ready, dbg_state);
    end
  endtask

  task automatic test_zero_msg();
    for (int i = 0; i < K; i++) msg_buf[i] = 8'h00;
    send_cw(K, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_impulse();
    for (int i = 0; i < K; i++) msg_buf[i] = 8'h00;
    msg_buf[K-1] = 8'h01;
    send_cw(K, 1'b0, 1'b1);
    wait_drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 4; c++) begin
      fill_random();
      send_cw(K, 1'b0, 1'b0);
    end
    wait_drain();
  endtask

  task automatic test_stall_gaps();
    rand_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      fill_random();
      send_cw(K, 1'b1, 1'b0);
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int run;
    int lasts;
    bit seen;
    run = 0;
    lasts = 0;
    seen = 1'b0;
    fork
      begin
        for (int c = 0; c < 3; c++) begin
          fill_random();
          send_cw(K, 1'b0, 1'b0);
        end
      end
      begin
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge i_clk);
          seen = o_valid;
        end
        while (seen && o_valid && run < 3 * N + 10) begin
          run++;
          if (o_last) lasts++;
          @(negedge i_clk);
        end
      end
    join
    n_cmp++;
    if (run != 3 * N) begin
      n_bad++;
      $display("FAIL b2b_beats: got %0d consecutive beats required %0d", run, 3 * N);
    end
    n_cmp++;
    if (lasts != 3) begin
      n_bad++;
      $display("FAIL b2b_last: got %0d o_last beats required 3", lasts);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    fill_random();
    send_cw(10, 1'b0, 1'b0);
    i_rst   = 1'b1;
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b0 || o_data !== 8'h00 || dbg_state !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_state: got valid=%0b data=%h state=%0b required 0/00/0",
               o_valid, o_data, dbg_state);
    end
    @(posedge i_clk);
    #1;
    test_impulse();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checking = 1'b1;
    test_reset();
    @(posedge i_clk);
    #1;
    test_zero_msg();
    test_impulse();
    test_random();
    test_stall_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
